// File: rtl/tlul_mask_gen_if.sv
// Request/beat handshake bundle for the byte-range to lane-mask beat generator.
// The slave modport is the generator; the master modport is whoever drives requests and sinks beats.
interface tlul_mask_gen_if #(
  parameter int W  = 8,
  parameter int AW = 32,
  parameter int LW = 16
);
  localparam int SZW = $clog2($clog2(W) + 1);

  logic           REQ_VALID;
  logic           REQ_READY;
  logic [AW-1:0]  REQ_ADDR;
  logic [LW-1:0]  REQ_LEN;
  logic           BEAT_VALID;
  logic           BEAT_READY;
  logic [AW-1:0]  BEAT_ADDR;
  logic [SZW-1:0] BEAT_SIZE;
  logic [W-1:0]   BEAT_MASK;
  logic           BEAT_LAST;
  logic           DONE;

  modport slave (
    input  REQ_VALID, REQ_ADDR, REQ_LEN, BEAT_READY,
    output REQ_READY, BEAT_VALID, BEAT_ADDR, BEAT_SIZE, BEAT_MASK, BEAT_LAST, DONE
  );

  modport master (
    output REQ_VALID, REQ_ADDR, REQ_LEN, BEAT_READY,
    input  REQ_READY, BEAT_VALID, BEAT_ADDR, BEAT_SIZE, BEAT_MASK, BEAT_LAST, DONE
  );
endinterface

// File: rtl/tlul_mask_gen.sv
// Splits a byte range into naturally aligned power-of-two beats, one per cycle, each with its lane mask.
//   state | meaning
//   IDLE  | waiting for a request, REQ_READY high
//   ISSUE | presenting beats until the LAST beat handshakes
//   FIN   | one-cycle DONE pulse, then back to IDLE
module tlul_mask_gen #(
  parameter int W  = 8,
  parameter int AW = 32,
  parameter int LW = 16
) (
  input logic            CLK,
  input logic            RST,
  tlul_mask_gen_if.slave bus
);
  localparam int LOG2W = $clog2(W);
  localparam int SZW   = $clog2(LOG2W + 1);

  if (W < 2 || (W & (W - 1)) != 0) begin : g_bad_w
    $error("tlul_mask_gen: W must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, FIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] remaining_q, remaining_d;

  logic [SZW-1:0] beat_size;
  logic [LW:0]    beat_bytes;
  logic [W-1:0]   beat_mask;
  logic           beat_last;
  logic           beat_hs;

  // Alignment and length constraints are monotone in s, so the last qualifying s is the largest.
  always_comb begin
    beat_size = '0;
    for (int s = 0; s <= LOG2W; s++) begin
      if (((cur_addr_q & AW'((1 << s) - 1)) == '0) &&
          ({1'b0, remaining_q} >= ((LW + 1)'(1) << s)))
        beat_size = SZW'(s);
    end
  end

  assign beat_bytes = (LW + 1)'(1) << beat_size;
  assign beat_last  = ({1'b0, remaining_q} == beat_bytes);

  always_comb begin
    beat_mask = '0;
    for (int i = 0; i < W; i++) begin
      if (i >= int'(cur_addr_q[LOG2W-1:0]) &&
          i <  int'(cur_addr_q[LOG2W-1:0]) + (1 << beat_size))
        beat_mask[i] = 1'b1;
    end
  end

  assign beat_hs = (state_q == ISSUE) && bus.BEAT_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          cur_addr_d  = bus.REQ_ADDR;
          remaining_d = bus.REQ_LEN;
          state_d     = (bus.REQ_LEN != '0) ? ISSUE : FIN;
        end
      end
      ISSUE: begin
        if (beat_hs) begin
          cur_addr_d  = cur_addr_q + (AW'(1) << beat_size);
          remaining_d = remaining_q - beat_bytes[LW-1:0];
          if (beat_last) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.REQ_READY  = 1'b0;
    bus.BEAT_VALID = 1'b0;
    bus.BEAT_ADDR  = '0;
    bus.BEAT_SIZE  = '0;
    bus.BEAT_MASK  = '0;
    bus.BEAT_LAST  = 1'b0;
    bus.DONE       = 1'b0;
    unique case (state_q)
      IDLE: bus.REQ_READY = 1'b1;
      ISSUE: begin
        bus.BEAT_VALID = 1'b1;
        bus.BEAT_ADDR  = cur_addr_q;
        bus.BEAT_SIZE  = beat_size;
        bus.BEAT_MASK  = beat_mask;
        bus.BEAT_LAST  = beat_last;
      end
      FIN:     bus.DONE = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_tlul_mask_gen.sv
// Directed bench for tlul_mask_gen at W=8: hand-computed beat sequences, stalls, LEN=0 and reset cases.
module tb_tlul_mask_gen;
  localparam int W  = 8;
  localparam int AW = 32;
  localparam int LW = 16;

  logic CLK = 1'b0;
  logic RST;

  tlul_mask_gen_if #(.W(W), .AW(AW), .LW(LW)) bus ();

  tlul_mask_gen #(.W(W), .AW(AW), .LW(LW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_addr [8];
  int          exp_size [8];
  logic [7:0]  exp_mask [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] shape_mask(input logic [31:0] addr, input int size);
    logic [15:0] run;
    run = (16'd1 << (1 << size)) - 16'd1;
    return 8'(run << addr[2:0]);
  endfunction

  task automatic set_beat(input int i, input logic [31:0] a, input int s, input logic [7:0] m);
    exp_addr[i] = a;
    exp_size[i] = s;
    exp_mask[i] = m;
  endtask

  task automatic check_beat(input string tag, input int i, input int nb);
    check({tag, " valid"}, 64'(bus.BEAT_VALID), 64'd1);
    check({tag, " addr"},  64'(bus.BEAT_ADDR),  64'(exp_addr[i]));
    check({tag, " size"},  64'(bus.BEAT_SIZE),  64'(exp_size[i]));
    check({tag, " mask"},  64'(bus.BEAT_MASK),  64'(exp_mask[i]));
    check({tag, " last"},  64'(bus.BEAT_LAST),  64'(i == nb - 1));
    check({tag, " rdy"},   64'(bus.REQ_READY),  64'd0);
    check({tag, " done"},  64'(bus.DONE),       64'd0);
    check({tag, " shape"}, 64'(bus.BEAT_MASK),  64'(shape_mask(bus.BEAT_ADDR, int'(bus.BEAT_SIZE))));
    check({tag, " align"}, 64'(bus.BEAT_ADDR & ((32'd1 << bus.BEAT_SIZE) - 32'd1)), 64'd0);
  endtask

  // Request issued at a negedge; every later sample and drive also happens at a negedge.
  task automatic run_req(input string tag, input logic [31:0] addr, input logic [15:0] len,
                         input int nb, input int stall_idx, input int stall_n, input bit hold_valid);
    int sum;
    sum = 0;
    check({tag, " idle rdy"}, 64'(bus.REQ_READY), 64'd1);
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = addr;
    bus.REQ_LEN   = len;
    @(negedge CLK);
    if (hold_valid) begin
      bus.REQ_ADDR = 32'h40;
      bus.REQ_LEN  = 16'd8;
    end else begin
      bus.REQ_VALID = 1'b0;
    end
    for (int i = 0; i < nb; i++) begin
      check_beat($sformatf("%s b%0d", tag, i), i, nb);
      sum += 1 << int'(bus.BEAT_SIZE);
      if (i == stall_idx) begin
        bus.BEAT_READY = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          @(negedge CLK);
          check_beat($sformatf("%s stall%0d", tag, k), i, nb);
        end
        bus.BEAT_READY = 1'b1;
      end
      @(negedge CLK);
    end
    bus.REQ_VALID = 1'b0;
    check({tag, " fin done"},  64'(bus.DONE),       64'd1);
    check({tag, " fin valid"}, 64'(bus.BEAT_VALID), 64'd0);
    check({tag, " fin rdy"},   64'(bus.REQ_READY),  64'd0);
    check({tag, " len sum"},   64'(sum),            64'(len));
    @(negedge CLK);
    check({tag, " post done"}, 64'(bus.DONE),       64'd0);
    check({tag, " post rdy"},  64'(bus.REQ_READY),  64'd1);
    check({tag, " post vld"},  64'(bus.BEAT_VALID), 64'd0);
  endtask

  initial begin
    RST            = 1'b1;
    bus.REQ_VALID  = 1'b1;
    bus.REQ_ADDR   = 32'h0;
    bus.REQ_LEN    = 16'd8;
    bus.BEAT_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst rdy",   64'(bus.REQ_READY),  64'd1);
    check("rst valid", 64'(bus.BEAT_VALID), 64'd0);
    check("rst addr",  64'(bus.BEAT_ADDR),  64'd0);
    check("rst size",  64'(bus.BEAT_SIZE),  64'd0);
    check("rst mask",  64'(bus.BEAT_MASK),  64'd0);
    check("rst last",  64'(bus.BEAT_LAST),  64'd0);
    check("rst done",  64'(bus.DONE),       64'd0);
    bus.REQ_VALID = 1'b0;
    RST = 1'b0;
    @(negedge CLK);
    check("idle valid", 64'(bus.BEAT_VALID), 64'd0);

    set_beat(0, 32'h00, 3, 8'hFF);
    run_req("full", 32'h00, 16'd8, 1, -1, 0, 1'b0);

    set_beat(0, 32'h03, 0, 8'h08);
    set_beat(1, 32'h04, 2, 8'hF0);
    set_beat(2, 32'h08, 0, 8'h01);
    run_req("odd", 32'h03, 16'd6, 3, -1, 0, 1'b0);

    set_beat(0, 32'h06, 1, 8'hC0);
    set_beat(1, 32'h08, 3, 8'hFF);
    set_beat(2, 32'h10, 3, 8'hFF);
    set_beat(3, 32'h18, 1, 8'h03);
    run_req("long", 32'h06, 16'd20, 4, -1, 0, 1'b0);

    set_beat(0, 32'h03, 0, 8'h08);
    set_beat(1, 32'h04, 2, 8'hF0);
    set_beat(2, 32'h08, 0, 8'h01);
    run_req("stall", 32'h03, 16'd6, 3, 1, 3, 1'b1);

    set_beat(0, 32'hFFFF_FFFE, 1, 8'hC0);
    set_beat(1, 32'h0000_0000, 1, 8'h03);
    run_req("wrap", 32'hFFFF_FFFE, 16'd4, 2, -1, 0, 1'b0);

    // LEN=0: straight to the DONE pulse with no beat
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 32'h05;
    bus.REQ_LEN   = 16'd0;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    check("len0 valid", 64'(bus.BEAT_VALID), 64'd0);
    check("len0 done",  64'(bus.DONE),       64'd1);
    check("len0 rdy",   64'(bus.REQ_READY),  64'd0);
    @(negedge CLK);
    check("len0 post done", 64'(bus.DONE),       64'd0);
    check("len0 post rdy",  64'(bus.REQ_READY),  64'd1);
    check("len0 post vld",  64'(bus.BEAT_VALID), 64'd0);

    // Reset during the second beat of the long request
    bus.REQ_VALID = 1'b1;
    bus.REQ_ADDR  = 32'h06;
    bus.REQ_LEN   = 16'd20;
    @(negedge CLK);
    bus.REQ_VALID = 1'b0;
    check("mid b0 addr", 64'(bus.BEAT_ADDR), 64'h06);
    @(negedge CLK);
    check("mid b1 addr", 64'(bus.BEAT_ADDR), 64'h08);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mid rst valid", 64'(bus.BEAT_VALID), 64'd0);
    check("mid rst rdy",   64'(bus.REQ_READY),  64'd1);
    check("mid rst done",  64'(bus.DONE),       64'd0);
    check("mid rst addr",  64'(bus.BEAT_ADDR),  64'd0);
    @(negedge CLK);
    check("mid idle vld",  64'(bus.BEAT_VALID), 64'd0);
    check("mid idle done", 64'(bus.DONE),       64'd0);

    set_beat(0, 32'h06, 1, 8'hC0);
    set_beat(1, 32'h08, 3, 8'hFF);
    set_beat(2, 32'h10, 3, 8'hFF);
    set_beat(3, 32'h18, 1, 8'h03);
    run_req("rerun", 32'h06, 16'd20, 4, -1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tlul_mask_gen.md
TLUL_MASK_GEN -- requirements
Module: tlul_mask_gen

Interface
REQ-001 SHALL have parameter W, default 8, meaning bus width in bytes; power of 2, >= 2; other values raise an elaboration error.
REQ-002 SHALL have parameter AW, default 32, meaning byte-address width.
REQ-003 SHALL have parameter LW, default 16, meaning request byte-length width.
REQ-004 SHALL have localparam SZW = $clog2($clog2(W)+1), meaning BEAT_SIZE width.
REQ-005 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port REQ_VALID  input  1  byte-range request present.
REQ-008 SHALL have port REQ_READY  output  1  block accepts a request.
REQ-009 SHALL have port REQ_ADDR  input  AW  start byte address, any alignment.
REQ-010 SHALL have port REQ_LEN  input  LW  byte count; 0 is legal.
REQ-011 SHALL have port BEAT_VALID  output  1  beat present.
REQ-012 SHALL have port BEAT_READY  input  1  downstream accepts the beat.
REQ-013 SHALL have port BEAT_ADDR  output  AW  beat address, aligned to 2**BEAT_SIZE.
REQ-014 SHALL have port BEAT_SIZE  output  SZW  log2 of beat bytes, range 0..log2(W).
REQ-015 SHALL have port BEAT_MASK  output  W  byte-lane mask.
REQ-016 SHALL have port BEAT_LAST  output  1  final beat of the request.
REQ-017 SHALL have port DONE  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, ISSUE, FIN.
REQ-019 SHALL drive REQ_READY=1 only in IDLE; acceptance occurs on REQ_VALID && REQ_READY.
REQ-020 SHALL latch REQ_ADDR into cur_addr and REQ_LEN into remaining on acceptance, then go to ISSUE if REQ_LEN != 0, else to FIN.
REQ-021 SHALL present the first beat (BEAT_VALID=1) in the cycle after acceptance.
REQ-022 SHALL set BEAT_SIZE, each beat, to the largest s <= log2(W) with cur_addr mod 2**s == 0 and 2**s <= remaining.
REQ-023 SHALL set BEAT_ADDR = cur_addr and BEAT_MASK = ((1<<2**s)-1) << (cur_addr mod W), i.e. contiguous, naturally aligned, power-of-two lane run, never zero.
REQ-024 SHALL set BEAT_LAST=1 when remaining == 2**s.
REQ-025 SHALL hold BEAT_ADDR/SIZE/MASK/LAST stable while BEAT_VALID && !BEAT_READY.
REQ-026 SHALL, on beat handshake, add 2**s to cur_addr (mod 2**AW, wrap permitted) and subtract 2**s from remaining, presenting the next beat in the following cycle (one beat per cycle sustained).
REQ-027 SHALL go to FIN on handshake of the BEAT_LAST beat.
REQ-028 SHALL, in FIN, drive DONE=1, REQ_READY=0, BEAT_VALID=0 for exactly one cycle, then go to IDLE.
REQ-029 SHALL never drop BEAT_VALID in ISSUE until the handshake.
REQ-030 SHALL compute beat fields from registered state only; there is no combinational path from REQ_* or BEAT_READY to beat fields.
REQ-031 SHALL ignore REQ_* outside IDLE.

Reset
REQ-032 SHALL, with RST=1 at a rising edge, enter IDLE and clear cur_addr and remaining, from any state including mid-request, discarding it.
REQ-033 SHALL reset outputs to REQ_READY=1 (IDLE), BEAT_VALID=0, BEAT_ADDR=0, BEAT_SIZE=0, BEAT_MASK=0, BEAT_LAST=0, DONE=0.
REQ-034 SHALL allow RST asserted together with REQ_VALID; reset wins and no request is accepted.

Verification (W=8)
REQ-035 SHALL cover: ADDR=0x00, LEN=8 -> one beat {0x00, size 3, mask 0xFF, LAST}, DONE pulse the cycle after that handshake.
REQ-036 SHALL cover: ADDR=0x03, LEN=6 -> beats {0x03,0,0x08}, {0x04,2,0xF0}, {0x08,0,0x01,LAST}.
REQ-037 SHALL cover: ADDR=0x06, LEN=20 -> beats {0x06,1,0xC0}, {0x08,3,0xFF}, {0x10,3,0xFF}, {0x18,1,0x03,LAST}; with BEAT_READY held 1, on consecutive cycles.
REQ-038 SHALL cover: REQ_VALID held and BEAT_READY=0 for 3 cycles on the 2nd beat of REQ-036 -> beat fields unchanged, REQ_READY=0 throughout, sequence resumes unaltered.
REQ-039 SHALL cover: LEN=0 at ADDR=0x05 -> no BEAT_VALID, DONE=1 exactly one cycle after acceptance, REQ_READY=1 the cycle after.
REQ-040 SHALL cover: RST pulsed during the 2nd beat of REQ-037 -> next cycle BEAT_VALID=0, REQ_READY=1, DONE=0; a new request then runs from scratch.
REQ-041 SHALL check, on every beat in all scenarios, that BEAT_MASK is a contiguous aligned power-of-two run matching BEAT_SIZE and BEAT_ADDR, and that the sum of 2**BEAT_SIZE equals REQ_LEN.
